// File: rtl/lsu_writeback_stage.sv
// Memory/writeback stage: runs loads/stores on a req/gnt/rvalid bus, splits misaligned accesses, drives the register-file write port.
// Latency: non-memory ops complete in the same cycle; memory ops complete on the final rvalid (aligned 2 cycles, split 4 with immediate gnt/rvalid).
// Backpressure: stall_o holds stage-2 and upstream until the final response; request fields are held stable until gnt.
module lsu_writeback_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] alu_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_wr_i,
    input  logic            cs_i,
    input  logic            rd_en_i,
    input  logic [1:0]      wb_sel_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            is_compressed_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_en_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            stall_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_LO, S_REQ_HI, S_WAIT_HI} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_lo;

    logic [1:0]        w_off;
    logic [2:0]        w_size;
    logic [3:0]        w_mask;
    logic [7:0]        w_be64;
    logic              w_split;
    logic              w_mem;
    logic              w_rsp_lo;
    logic              w_final;
    logic [XLEN-1:0]   w_lo_addr;
    logic [XLEN-1:0]   w_hi_addr;
    logic [2*XLEN-1:0] w_rot64;
    logic [XLEN-1:0]   w_wdata;
    logic [2*XLEN-1:0] w_pair;
    logic [2*XLEN-1:0] w_shifted;
    logic [XLEN-1:0]   w_raw;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_link;

    assign w_off   = alu_i[1:0];
    // funct3[1:0]=11 has no defined size; treat it as a word
    assign w_size  = (funct3_i[1:0] == 2'b00) ? 3'd1 :
                     (funct3_i[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign w_mask  = (w_size == 3'd1) ? 4'b0001 :
                     (w_size == 3'd2) ? 4'b0011 : 4'b1111;
    assign w_be64  = {4'b0000, w_mask} << w_off;
    assign w_split = ({1'b0, w_off} + w_size) > 3'd4;

    // Reset gates everything combinational so no bus activity escapes while it is held
    assign w_mem    = valid_i & cs_i & ~reset;
    assign w_rsp_lo = (r_state == S_WAIT_LO) & dmem_rvalid_i;
    assign w_final  = w_mem & ((w_rsp_lo & ~w_split) |
                               ((r_state == S_WAIT_HI) & dmem_rvalid_i));

    assign w_lo_addr = {alu_i[XLEN-1:2], 2'b00};
    assign w_hi_addr = w_lo_addr + 32'd4;

    // Upper half of {d,d} << k is d rotated left by k
    assign w_rot64 = {store_data_i, store_data_i} << {w_off, 3'b000};
    assign w_wdata = w_rot64[2*XLEN-1:XLEN];

    // The hi word only exists for split accesses; otherwise the current rdata is the whole access
    assign w_pair    = w_split ? {dmem_rdata_i, r_lo} : {{XLEN{1'b0}}, dmem_rdata_i};
    assign w_shifted = w_pair >> {w_off, 3'b000};
    assign w_raw     = w_shifted[XLEN-1:0];

    assign w_link = pc_i + (is_compressed_i ? 32'd2 : 32'd4);

    // Truncate merged load data to access size and extend (funct3[2] selects zero-extension)
    always_comb begin
        w_load = w_raw;
        if (w_size == 3'd1) begin
            w_load = funct3_i[2] ? {24'd0, w_raw[7:0]} : {{24{w_raw[7]}}, w_raw[7:0]};
        end else if (w_size == 3'd2) begin
            w_load = funct3_i[2] ? {16'd0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
        end
    end

    // State register and lo-word capture on the first beat of a split access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mem && w_rsp_lo && w_split) begin
                r_lo <= dmem_rdata_i;
            end
        end
    end

    // Next-state and bus request outputs
    always_comb begin
        w_state_nxt  = r_state;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = w_lo_addr;
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = '0;
        case (r_state)
            S_IDLE: begin
                if (w_mem) begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = ~rd_en_i;
                    dmem_be_o    = rd_en_i ? 4'b1111 : w_be64[3:0];
                    dmem_wdata_o = rd_en_i ? '0 : w_wdata;
                    if (dmem_gnt_i) begin
                        w_state_nxt = S_WAIT_LO;
                    end
                end
            end
            S_WAIT_LO: begin
                if (dmem_rvalid_i) begin
                    w_state_nxt = w_split ? S_REQ_HI : S_IDLE;
                end
            end
            S_REQ_HI: begin
                dmem_addr_o = w_hi_addr;
                if (w_mem) begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = ~rd_en_i;
                    dmem_be_o    = rd_en_i ? 4'b1111 : w_be64[7:4];
                    dmem_wdata_o = rd_en_i ? '0 : w_wdata;
                    if (dmem_gnt_i) begin
                        w_state_nxt = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                dmem_addr_o = w_hi_addr;
                if (dmem_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Writeback select and strobe; memory ops write only on the final load response
    always_comb begin
        wb_rd_o = rd_i;
        case (wb_sel_i)
            2'b00:   wb_data_o = alu_i;
            2'b01:   wb_data_o = w_load;
            2'b10:   wb_data_o = w_link;
            default: wb_data_o = csr_rdata_i;
        endcase
        wb_en_o = ~reset & valid_i & reg_wr_i & (rd_i != 5'd0) &
                  (cs_i ? (w_final & rd_en_i) : 1'b1);
        stall_o = w_mem & ~w_final;
    end

endmodule

// File: tb/tb_lsu_writeback_stage.sv
// Directed bench for lsu_writeback_stage: bus responses are driven by hand cycle by cycle.
// Inputs change just after each falling edge; outputs are checked 1ns later, away from the rising edge.
// Responder never stalls the bench indefinitely: every step is a fixed cycle.
module tb_lsu_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, reg_wr_i, cs_i, rd_en_i, is_compressed_i;
    logic [31:0] pc_i, alu_i, store_data_i, csr_rdata_i;
    logic [4:0]  rd_i;
    logic [1:0]  wb_sel_i;
    logic [2:0]  funct3_i;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_be_o;
    logic        wb_en_o, stall_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_writeback_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .alu_i(alu_i),
        .rd_i(rd_i), .reg_wr_i(reg_wr_i), .cs_i(cs_i), .rd_en_i(rd_en_i),
        .wb_sel_i(wb_sel_i), .funct3_i(funct3_i), .store_data_i(store_data_i),
        .is_compressed_i(is_compressed_i), .csr_rdata_i(csr_rdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .stall_o(stall_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle's drive point
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bus(input logic g, input logic rv, input logic [31:0] rdat);
        dmem_gnt_i    = g;
        dmem_rvalid_i = rv;
        dmem_rdata_i  = rdat;
    endtask

    task automatic idle_in();
        valid_i = 1'b0; cs_i = 1'b0; rd_en_i = 1'b0; reg_wr_i = 1'b0;
        wb_sel_i = 2'b00; funct3_i = 3'b010; rd_i = 5'd0;
        pc_i = 32'h0; alu_i = 32'h0; store_data_i = 32'h0;
        is_compressed_i = 1'b0; csr_rdata_i = 32'h0;
        bus(1'b0, 1'b0, 32'h0);
    endtask

    task automatic mem_op(input logic [2:0] f3, input logic [31:0] a, input logic ld,
                          input logic [4:0] rd, input logic [31:0] sd);
        valid_i = 1'b1; cs_i = 1'b1; rd_en_i = ld; reg_wr_i = ld;
        wb_sel_i = ld ? 2'b01 : 2'b00; funct3_i = f3; alu_i = a; rd_i = rd;
        store_data_i = sd; pc_i = 32'h40;
    endtask

    // Aligned (non-split) load: gnt in cycle 1, rvalid in cycle 2
    task automatic aligned_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] rdat, input logic [31:0] exp_addr,
                                input logic [31:0] exp_wb);
        next_cyc(); mem_op(f3, a, 1'b1, 5'd6, 32'h0); bus(1'b1, 1'b0, 32'h0); settle();
        chk({tag, "_addr"}, dmem_addr_o, exp_addr);
        chk({tag, "_stall1"}, {31'd0, stall_o}, 32'd1);
        next_cyc(); bus(1'b0, 1'b1, rdat); settle();
        chk({tag, "_wb"}, wb_data_o, exp_wb);
        chk({tag, "_wben"}, {31'd0, wb_en_o}, 32'd1);
        chk({tag, "_stall2"}, {31'd0, stall_o}, 32'd0);
        next_cyc(); idle_in();
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        // Reset held with a memory op presented: nothing may leak out
        valid_i = 1'b1; cs_i = 1'b1; rd_en_i = 1'b0; reg_wr_i = 1'b1; rd_i = 5'd3;
        store_data_i = 32'hFFFF_FFFF; funct3_i = 3'b010;
        next_cyc(); next_cyc(); settle();
        chk("rst_req",   {31'd0, dmem_req_o}, 32'd0);
        chk("rst_wben",  {31'd0, wb_en_o},    32'd0);
        chk("rst_stall", {31'd0, stall_o},    32'd0);
        chk("rst_be",    {28'd0, dmem_be_o},  32'd0);
        chk("rst_wdata", dmem_wdata_o,        32'd0);
        next_cyc(); idle_in(); reset = 1'b0;

        // Aligned LW 0x100
        next_cyc(); mem_op(3'b010, 32'h100, 1'b1, 5'd5, 32'h0); bus(1'b1, 1'b0, 32'h0); settle();
        chk("lw_req",   {31'd0, dmem_req_o}, 32'd1);
        chk("lw_we",    {31'd0, dmem_we_o},  32'd0);
        chk("lw_addr",  dmem_addr_o,         32'h100);
        chk("lw_be",    {28'd0, dmem_be_o},  32'hF);
        chk("lw_stall", {31'd0, stall_o},    32'd1);
        chk("lw_wben0", {31'd0, wb_en_o},    32'd0);
        next_cyc(); bus(1'b0, 1'b1, 32'hDEADBEEF); settle();
        chk("lw_req2",  {31'd0, dmem_req_o}, 32'd0);
        chk("lw_stall2",{31'd0, stall_o},    32'd0);
        chk("lw_wben",  {31'd0, wb_en_o},    32'd1);
        chk("lw_wbrd",  {27'd0, wb_rd_o},    32'd5);
        chk("lw_wb",    wb_data_o,           32'hDEADBEEF);
        next_cyc(); idle_in();

        // Sub-word loads
        aligned_load("lb",  3'b000, 32'h103, 32'h80123456, 32'h100, 32'hFFFFFF80);
        aligned_load("lbu", 3'b100, 32'h103, 32'h80123456, 32'h100, 32'h00000080);
        aligned_load("lh",  3'b001, 32'h102, 32'h80123456, 32'h100, 32'hFFFF8012);
        aligned_load("lhu", 3'b101, 32'h102, 32'h80123456, 32'h100, 32'h00008012);

        // Misaligned LW 0x102
        next_cyc(); mem_op(3'b010, 32'h102, 1'b1, 5'd7, 32'h0); bus(1'b1, 1'b0, 32'h0); settle();
        chk("mlw_addr1", dmem_addr_o, 32'h100);
        chk("mlw_st1", {31'd0, stall_o}, 32'd1);
        next_cyc(); bus(1'b0, 1'b1, 32'h44332211); settle();
        chk("mlw_st2", {31'd0, stall_o}, 32'd1);
        chk("mlw_wben2", {31'd0, wb_en_o}, 32'd0);
        chk("mlw_req2", {31'd0, dmem_req_o}, 32'd0);
        next_cyc(); bus(1'b1, 1'b0, 32'h0); settle();
        chk("mlw_req3", {31'd0, dmem_req_o}, 32'd1);
        chk("mlw_addr3", dmem_addr_o, 32'h104);
        chk("mlw_be3", {28'd0, dmem_be_o}, 32'hF);
        chk("mlw_st3", {31'd0, stall_o}, 32'd1);
        next_cyc(); bus(1'b0, 1'b1, 32'h88776655); settle();
        chk("mlw_st4", {31'd0, stall_o}, 32'd0);
        chk("mlw_wben", {31'd0, wb_en_o}, 32'd1);
        chk("mlw_wb", wb_data_o, 32'h66554433);
        next_cyc(); idle_in();

        // Split SH 0x103
        next_cyc(); mem_op(3'b001, 32'h103, 1'b0, 5'd0, 32'h0000ABCD); bus(1'b1, 1'b0, 32'h0); settle();
        chk("sh_we1",    {31'd0, dmem_we_o}, 32'd1);
        chk("sh_addr1",  dmem_addr_o, 32'h100);
        chk("sh_be1",    {28'd0, dmem_be_o}, 32'h8);
        chk("sh_wdata1", dmem_wdata_o, 32'hCD0000AB);
        next_cyc(); bus(1'b0, 1'b1, 32'h0); settle();
        chk("sh_st2",   {31'd0, stall_o}, 32'd1);
        chk("sh_wben2", {31'd0, wb_en_o}, 32'd0);
        next_cyc(); bus(1'b1, 1'b0, 32'h0); settle();
        chk("sh_we3",    {31'd0, dmem_we_o}, 32'd1);
        chk("sh_addr3",  dmem_addr_o, 32'h104);
        chk("sh_be3",    {28'd0, dmem_be_o}, 32'h1);
        chk("sh_wdata3", dmem_wdata_o, 32'hCD0000AB);
        next_cyc(); bus(1'b0, 1'b1, 32'h0); settle();
        chk("sh_st4",   {31'd0, stall_o}, 32'd0);
        chk("sh_wben4", {31'd0, wb_en_o}, 32'd0);
        next_cyc(); idle_in();

        // Aligned SB 0x201: single beat, lane 1
        next_cyc(); mem_op(3'b000, 32'h201, 1'b0, 5'd0, 32'h000000A5); bus(1'b1, 1'b0, 32'h0); settle();
        chk("sb_be",    {28'd0, dmem_be_o}, 32'h2);
        chk("sb_wdata", dmem_wdata_o, 32'h0000A500);
        next_cyc(); bus(1'b0, 1'b1, 32'h0); settle();
        chk("sb_st2", {31'd0, stall_o}, 32'd0);
        next_cyc(); idle_in();

        // LW 0x300 with gnt delayed three cycles
        for (int i = 0; i < 3; i++) begin
            next_cyc(); mem_op(3'b010, 32'h300, 1'b1, 5'd9, 32'h0); bus(1'b0, 1'b0, 32'h0); settle();
            chk("dly_req",   {31'd0, dmem_req_o}, 32'd1);
            chk("dly_addr",  dmem_addr_o, 32'h300);
            chk("dly_be",    {28'd0, dmem_be_o}, 32'hF);
            chk("dly_stall", {31'd0, stall_o}, 32'd1);
        end
        next_cyc(); bus(1'b1, 1'b0, 32'h0); settle();
        chk("dly_req4",  {31'd0, dmem_req_o}, 32'd1);
        chk("dly_addr4", dmem_addr_o, 32'h300);
        next_cyc(); bus(1'b0, 1'b0, 32'h0); settle();
        chk("dly_wait_stall", {31'd0, stall_o}, 32'd1);
        chk("dly_wait_wben",  {31'd0, wb_en_o}, 32'd0);
        next_cyc(); bus(1'b0, 1'b1, 32'h12345678); settle();
        chk("dly_wb",   wb_data_o, 32'h12345678);
        chk("dly_wben", {31'd0, wb_en_o}, 32'd1);
        next_cyc(); idle_in();

        // Hi address wraps past the top of memory
        next_cyc(); mem_op(3'b010, 32'hFFFFFFFE, 1'b1, 5'd4, 32'h0); bus(1'b1, 1'b0, 32'h0); settle();
        chk("wrap_addr1", dmem_addr_o, 32'hFFFFFFFC);
        next_cyc(); bus(1'b0, 1'b1, 32'hBBAA0000); settle();
        next_cyc(); bus(1'b1, 1'b0, 32'h0); settle();
        chk("wrap_addr2", dmem_addr_o, 32'h0);
        next_cyc(); bus(1'b0, 1'b1, 32'h0000DDCC); settle();
        chk("wrap_wb", wb_data_o, 32'hDDCCBBAA);
        next_cyc(); idle_in();

        // Reset while in WAIT_HI
        next_cyc(); mem_op(3'b010, 32'h102, 1'b1, 5'd8, 32'h0); bus(1'b1, 1'b0, 32'h0);
        next_cyc(); bus(1'b0, 1'b1, 32'h11111111);
        next_cyc(); bus(1'b1, 1'b0, 32'h0);
        next_cyc(); bus(1'b0, 1'b0, 32'h0); reset = 1'b1; settle();
        chk("rstm_req",   {31'd0, dmem_req_o}, 32'd0);
        chk("rstm_stall", {31'd0, stall_o}, 32'd0);
        chk("rstm_wben",  {31'd0, wb_en_o}, 32'd0);
        // Late rvalid after reset lands in IDLE: new request starts, no writeback
        next_cyc(); reset = 1'b0; bus(1'b0, 1'b1, 32'h22222222); settle();
        chk("rstm_rv_wben",  {31'd0, wb_en_o}, 32'd0);
        chk("rstm_rv_stall", {31'd0, stall_o}, 32'd1);
        chk("rstm_rv_addr",  dmem_addr_o, 32'h100);
        next_cyc(); idle_in(); settle();
        chk("rstm_idle_req", {31'd0, dmem_req_o}, 32'd0);

        // Non-memory writebacks
        next_cyc(); valid_i = 1'b1; reg_wr_i = 1'b1; wb_sel_i = 2'b10; pc_i = 32'h200;
        is_compressed_i = 1'b1; rd_i = 5'd1; settle();
        chk("jal_wb",    wb_data_o, 32'h202);
        chk("jal_wben",  {31'd0, wb_en_o}, 32'd1);
        chk("jal_stall", {31'd0, stall_o}, 32'd0);
        chk("jal_req",   {31'd0, dmem_req_o}, 32'd0);
        rd_i = 5'd0; settle();
        chk("jal_x0_wben", {31'd0, wb_en_o}, 32'd0);
        next_cyc(); rd_i = 5'd2; pc_i = 32'hFFFFFFFE; is_compressed_i = 1'b0; settle();
        chk("jal_wrap", wb_data_o, 32'h00000002);
        next_cyc(); wb_sel_i = 2'b00; alu_i = 32'h13579BDF; settle();
        chk("alu_wb", wb_data_o, 32'h13579BDF);
        next_cyc(); wb_sel_i = 2'b11; csr_rdata_i = 32'hC5C5C5C5; settle();
        chk("csr_wb", wb_data_o, 32'hC5C5C5C5);
        next_cyc(); reg_wr_i = 1'b0; settle();
        chk("nowr_wben", {31'd0, wb_en_o}, 32'd0);
        next_cyc(); valid_i = 1'b0; reg_wr_i = 1'b1; settle();
        chk("inval_wben", {31'd0, wb_en_o}, 32'd0);
        next_cyc(); idle_in();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_writeback_stage.md
Name: lsu_writeback_stage

Overview:
- Final (memory/writeback) stage of the 3-stage core. Consumes the stage-2 pipeline register outputs: pc, alu result, rd, reg_wr, cs, rd_en, wb_sel.
- Executes loads and stores on a req/gnt/rvalid data bus.
- Splits misaligned accesses into two word transactions.
- Selects writeback data and drives the register-file write port. Asserts stall_o to freeze upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_i  in  1  stage-2 holds a valid instruction
- pc_i  in  32  instruction PC
- alu_i  in  32  ALU result; the memory address for cs_i=1
- rd_i  in  5  destination register
- reg_wr_i  in  1  register write enable
- cs_i  in  1  memory access instruction
- rd_en_i  in  1  1=load, 0=store (valid when cs_i=1)
- wb_sel_i  in  2  00 ALU, 01 load data, 10 PC+len, 11 CSR read data
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- store_data_i  in  32  rs2 value for stores
- is_compressed_i  in  1  1 = 16-bit instruction (link value is PC+2)
- csr_rdata_i  in  32  CSR read data
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word-aligned address (bits [1:0] = 0)
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  write data, byte-lane aligned
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  response valid (read data or store ack)
- dmem_rdata_i  in  32  read data
- wb_en_o  out  1  register-file write strobe
- wb_rd_o  out  5  write address (= rd_i)
- wb_data_o  out  32  write data
- stall_o  out  1  hold stage-2 register and upstream stages

Behaviour:
- Reset: state IDLE, lo-word register 0. While reset=1: dmem_req_o=0, wb_en_o=0, stall_o=0, dmem_be_o=0, dmem_wdata_o=0.
- Reset mid-operation: abandons any transaction; next cycle is IDLE with req=0. dmem_rvalid_i arriving in IDLE is ignored.
- Non-memory (valid_i & ~cs_i):
  - Zero latency; stall_o=0.
  - wb_en_o = valid_i & reg_wr_i & (rd_i != 0).
  - wb_data_o per wb_sel_i. Link value = pc_i + (is_compressed_i ? 2 : 4), wrapping mod 2^32.
- Memory ops:
  - off = alu_i[1:0]. Size: B=1, H=2, W=4; funct3[1:0]=11 is treated as W.
  - split = off + size > 4.
- FSM states: IDLE, WAIT_LO, REQ_HI, WAIT_HI.
  - IDLE: on valid_i & cs_i, assert req combinationally with addr = {alu_i[31:2],2'b00}. Stay in IDLE until gnt, then go to WAIT_LO.
  - WAIT_LO: on rvalid, if split go to REQ_HI (capture rdata into the lo register); else complete and go to IDLE.
  - REQ_HI: req with addr = lo addr + 4 (wraps at 0xFFFFFFFC -> 0). On gnt go to WAIT_HI.
  - WAIT_HI: on rvalid, complete and go to IDLE.
- Request fields are held stable from req assertion until gnt. Only one outstanding transaction at a time.
- Store lanes:
  - mask = (1<<size)-1; be64 = mask << off.
  - Lo beat be = be64[3:0], hi beat be = be64[7:4].
  - wdata = store_data_i rotated left by 8*off, identical on both beats.
- Loads: be=1111 on both beats. Merged = ({hi,lo} >> 8*off), where for non-split accesses hi = don't care and lo = rdata. Then truncate to size; sign-extend for B/H, zero-extend for BU/HU.
- Completion cycle (final rvalid):
  - Load: wb_en_o = reg_wr_i & (rd_i != 0). wb_data_o = merged load data, or per wb_sel_i if wb_sel_i != 01.
  - Store: wb_en_o=0.
- stall_o = valid_i & cs_i & ~(final rvalid this cycle). With gnt in the request cycle and rvalid the next cycle, an aligned access occupies 2 cycles (1 stall cycle) and a split access 4 cycles.
- wb_en_o=0 in all non-completion cycles of a memory op. Upstream guarantees inputs stay stable while stall_o=1.

Test Plan:
- Aligned LW 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> addr 0x100, be 1111, stall 1 cycle, wb_data 0xDEADBEEF, wb_en 1 (rd=5).
- LB 0x103, rdata 0x80123456 -> wb 0xFFFFFF80. LBU same -> 0x00000080. LH 0x102 -> 0xFFFF8012.
- Misaligned LW 0x102; mem[0x100]=0x44332211, mem[0x104]=0x88776655 -> two reqs (0x100, then 0x104), wb 0x66554433, stall 3 cycles.
- SH 0x103, data 0x0000ABCD -> beat1: addr 0x100, be 1000, wdata 0xCD0000AB. Beat2: addr 0x104, be 0001, same wdata. wb_en stays 0.
- gnt delayed 3 cycles on LW -> req/addr/be stable for 4 cycles, stall held until rvalid. Reset asserted in WAIT_HI -> next cycle req 0, stall 0; a following rvalid produces no wb_en.
- Non-memory JAL: wb_sel 10, pc 0x200, is_compressed 1, rd 1 -> same cycle wb_data 0x202, wb_en 1, stall 0. Same with rd=0 -> wb_en 0.
